// File: rtl/l2_ddr_refill_ctrl.sv
// DDR-to-L2 refill engine: issues BURST_LINES-beat DDR reads when L2 has room and
// drains the returned lines into L2 port B. Optional counters: L2_REFILL_STATS_EN.
module l2_ddr_refill_ctrl #(
    parameter int unsigned DDR_ADDR_W  = 28,
    parameter int unsigned BURST_LINES = 8,
    parameter int unsigned LEN_W       = 8
) (
    input  logic                  clk_166M66,
    input  logic                  mcu_sys_rst,
    input  logic                  i_refill_enable,
    input  logic                  i_start_load,
    input  logic [DDR_ADDR_W-1:0] i_start_address,
    input  logic [11:0]           i_l2_unread_size,
    input  logic                  i_l1ddr_rw_confilicts,
    output logic                  o_ddr_rd_req,
    input  logic                  i_ddr_rd_ack,
    output logic [DDR_ADDR_W-1:0] o_ddr_rd_addr,
    output logic [LEN_W-1:0]      o_ddr_rd_len,
    input  logic                  i_ddr_rd_valid,
    input  logic [127:0]          i_ddr_rd_data,
    output logic                  o_l2_ddr_operate_enable,
    output logic                  o_l2_ddr_rw,
    output logic [127:0]          o_l2_ddr_data,
    output logic                  o_busy,
    output logic                  o_err_unexpected
`ifdef L2_REFILL_STATS_EN
    ,
    output logic [15:0]           o_burst_done_cnt,
    output logic [15:0]           o_conflict_stall_cnt
`endif
);

    localparam int unsigned           PTR_W     = $clog2(BURST_LINES);
    localparam logic [11:0]           FREE_NEED = 12'(BURST_LINES * 8);
    localparam logic [DDR_ADDR_W-1:0] ADDR_STEP = DDR_ADDR_W'(BURST_LINES * 16);
    localparam logic [PTR_W:0]        DEPTH     = (PTR_W + 1)'(BURST_LINES);
    localparam logic [PTR_W:0]        LAST_BEAT = (PTR_W + 1)'(BURST_LINES - 1);
    localparam logic [PTR_W:0]        PTR_ZERO  = (PTR_W + 1)'(0);
    localparam logic [PTR_W:0]        PTR_ONE   = (PTR_W + 1)'(1);
    localparam logic [LEN_W-1:0]      LEN_VAL   = LEN_W'(BURST_LINES);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_REQ        = 2'd1,
        ST_RECV       = 2'd2,
        ST_WAIT_DRAIN = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [DDR_ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [PTR_W:0]        beat_q, beat_d;
    logic [PTR_W:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]        rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]        mask_q, mask_d;
    logic                  err_q, err_d;
    logic [127:0]          last_data_q, last_data_d;
    logic [127:0]          buf_q [BURST_LINES];

    logic [11:0]  free_s;
    logic         empty_s;
    logic         full_s;
    logic         push_s;
    logic         pop_s;
    logic         bad_beat_s;
    logic [127:0] head_s;

    assign free_s     = 12'hFFF - i_l2_unread_size;
    assign empty_s    = (wr_ptr_q == rd_ptr_q);
    assign full_s     = ((wr_ptr_q - rd_ptr_q) == DEPTH);
    assign push_s     = i_ddr_rd_valid && (state_q == ST_RECV) && !full_s;
    assign pop_s      = !empty_s && !i_l1ddr_rw_confilicts;
    assign bad_beat_s = i_ddr_rd_valid && !push_s;
    assign head_s     = buf_q[rd_ptr_q[PTR_W-1:0]];

    // Burst sequencing and DDR request address/length.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        beat_d  = beat_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start_load && empty_s) begin
                    addr_d = i_start_address;
                end else begin
                    addr_d = addr_q;
                end
                if (i_refill_enable && empty_s && (free_s >= FREE_NEED)) begin
                    state_d = ST_REQ;
                    len_d   = LEN_VAL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (i_ddr_rd_ack) begin
                    state_d = ST_RECV;
                    beat_d  = PTR_ZERO;
                    addr_d  = addr_q + ADDR_STEP;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_RECV: begin
                if (push_s) begin
                    beat_d = beat_q + PTR_ONE;
                    if (beat_q == LAST_BEAT) begin
                        state_d = ST_WAIT_DRAIN;
                    end else begin
                        state_d = ST_RECV;
                    end
                end else begin
                    state_d = ST_RECV;
                end
            end
            ST_WAIT_DRAIN: begin
                if (empty_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Holding-buffer pointers, last-written line and sticky error. Stray beats
    // from a burst cut short by reset are not flagged while mask_q counts down.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        last_data_d = last_data_q;
        mask_d      = mask_q;
        err_d       = err_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d    = rd_ptr_q + PTR_ONE;
            last_data_d = head_s;
        end else begin
            rd_ptr_d    = rd_ptr_q;
            last_data_d = last_data_q;
        end
        if (mask_q != PTR_ZERO) begin
            mask_d = mask_q - PTR_ONE;
        end else begin
            mask_d = PTR_ZERO;
        end
        if (bad_beat_s && (mask_q == PTR_ZERO)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_166M66) begin
        if (mcu_sys_rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= {DDR_ADDR_W{1'b0}};
            len_q       <= {LEN_W{1'b0}};
            beat_q      <= PTR_ZERO;
            wr_ptr_q    <= PTR_ZERO;
            rd_ptr_q    <= PTR_ZERO;
            mask_q      <= DEPTH;
            err_q       <= 1'b0;
            last_data_q <= 128'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mask_q      <= mask_d;
            err_q       <= err_d;
            last_data_q <= last_data_d;
        end
    end

    // Line storage; validity is tracked by the pointers, so no reset needed.
    always_ff @(posedge clk_166M66) begin
        if (push_s) begin
            buf_q[wr_ptr_q[PTR_W-1:0]] <= i_ddr_rd_data;
        end
    end

    assign o_ddr_rd_req            = (state_q == ST_REQ);
    assign o_ddr_rd_addr           = addr_q;
    assign o_ddr_rd_len            = len_q;
    assign o_l2_ddr_operate_enable = pop_s;
    assign o_l2_ddr_rw             = pop_s;
    assign o_l2_ddr_data           = pop_s ? head_s : last_data_q;
    assign o_busy                  = (state_q != ST_IDLE) || !empty_s;
    assign o_err_unexpected        = err_q;

`ifdef L2_REFILL_STATS_EN
    logic [15:0] burst_cnt_q, burst_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating activity counters.
    always_comb begin
        burst_cnt_d = burst_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if ((state_q == ST_WAIT_DRAIN) && empty_s && (burst_cnt_q != 16'hFFFF)) begin
            burst_cnt_d = burst_cnt_q + 16'd1;
        end else begin
            burst_cnt_d = burst_cnt_q;
        end
        if (!empty_s && i_l1ddr_rw_confilicts && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk_166M66) begin
        if (mcu_sys_rst) begin
            burst_cnt_q <= 16'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_burst_done_cnt     = burst_cnt_q;
    assign o_conflict_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_l2_ddr_refill_ctrl.sv
// Self-checking bench for l2_ddr_refill_ctrl: scoreboard of DDR beats versus L2 writes.
module tb_l2_ddr_refill_ctrl;

    logic          clk = 1'b0;
    logic          rst;
    logic          en, load, ack, valid, conflict;
    logic [27:0]   start_addr;
    logic [11:0]   unread;
    logic [127:0]  rd_data;
    logic          req, l2_en, l2_rw, busy, err;
    logic [27:0]   rd_addr;
    logic [7:0]    rd_len;
    logic [127:0]  l2_data;

    int            vectors = 0;
    int            miscompares = 0;
    int            cyc = 0;
    int            wr_cnt = 0;
    int            first_wr_cyc = -1;
    int            last_wr_cyc = -1;
    bit            gap_seen = 1'b0;
    logic [127:0]  sb [$];

    always #3 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    l2_ddr_refill_ctrl dut (
        .clk_166M66              (clk),
        .mcu_sys_rst             (rst),
        .i_refill_enable         (en),
        .i_start_load            (load),
        .i_start_address         (start_addr),
        .i_l2_unread_size        (unread),
        .i_l1ddr_rw_confilicts   (conflict),
        .o_ddr_rd_req            (req),
        .i_ddr_rd_ack            (ack),
        .o_ddr_rd_addr           (rd_addr),
        .o_ddr_rd_len            (rd_len),
        .i_ddr_rd_valid          (valid),
        .i_ddr_rd_data           (rd_data),
        .o_l2_ddr_operate_enable (l2_en),
        .o_l2_ddr_rw             (l2_rw),
        .o_l2_ddr_data           (l2_data),
        .o_busy                  (busy),
        .o_err_unexpected        (err)
    );

    // Every L2 write must match the oldest outstanding DDR beat.
    always @(negedge clk) begin
        if (l2_en === 1'b1) begin
            if (wr_cnt > 0 && cyc != last_wr_cyc + 1) gap_seen = 1'b1;
            if (wr_cnt == 0) first_wr_cyc = cyc;
            last_wr_cyc = cyc;
            wr_cnt++;
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL l2_write_unexpected: got data %h, required no write", l2_data);
            end else begin
                logic [127:0] exp_d;
                exp_d = sb.pop_front();
                if (l2_data !== exp_d || l2_rw !== 1'b1) begin
                    miscompares++;
                    $display("FAIL l2_write_data: got %h rw %b, required %h rw 1", l2_data, l2_rw, exp_d);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        tick();
        rst = 1'b1; en = 1'b0; load = 1'b0; ack = 1'b0; valid = 1'b0; conflict = 1'b0;
        start_addr = 28'h0; unread = 12'h0; rd_data = 128'd0;
        tick();
        tick();
        rst = 1'b0;
        wr_cnt = 0; first_wr_cyc = -1; last_wr_cyc = -1; gap_seen = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        vectors++; if (req !== 1'b0) begin miscompares++; $display("FAIL rst_req: got %b, required 0", req); end
        vectors++; if (rd_addr !== 28'h0) begin miscompares++; $display("FAIL rst_addr: got %h, required 0", rd_addr); end
        vectors++; if (rd_len !== 8'h0) begin miscompares++; $display("FAIL rst_len: got %h, required 0", rd_len); end
        vectors++; if (l2_en !== 1'b0) begin miscompares++; $display("FAIL rst_l2_en: got %b, required 0", l2_en); end
        vectors++; if (l2_rw !== 1'b0) begin miscompares++; $display("FAIL rst_l2_rw: got %b, required 0", l2_rw); end
        vectors++; if (l2_data !== 128'd0) begin miscompares++; $display("FAIL rst_l2_data: got %h, required 0", l2_data); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b, required 0", busy); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %b, required 0", err); end
    endtask

    task automatic test_basic_burst();
        int  beat0;
        bit  done;
        apply_reset();
        start_addr = 28'h0000100; load = 1'b1; en = 1'b1;
        @(negedge clk);
        vectors++; if (req !== 1'b0) begin miscompares++; $display("FAIL basic_req_eval: got %b, required 0", req); end
        tick(); load = 1'b0;
        @(negedge clk);
        vectors++; if (req !== 1'b1) begin miscompares++; $display("FAIL basic_req: got %b, required 1", req); end
        vectors++; if (rd_addr !== 28'h0000100) begin miscompares++; $display("FAIL basic_addr: got %h, required 0000100", rd_addr); end
        vectors++; if (rd_len !== 8'd8) begin miscompares++; $display("FAIL basic_len: got %0d, required 8", rd_len); end
        tick(); load = 1'b1; start_addr = 28'h0005550;
        tick(); load = 1'b0;
        @(negedge clk);
        vectors++; if (req !== 1'b1 || rd_addr !== 28'h0000100) begin miscompares++; $display("FAIL basic_load_in_req: got req %b addr %h, required req 1 addr 0000100", req, rd_addr); end
        tick(); ack = 1'b1;
        tick(); ack = 1'b0; en = 1'b0;
        @(negedge clk);
        vectors++; if (req !== 1'b0 || rd_addr !== 28'h0000180) begin miscompares++; $display("FAIL basic_after_ack: got req %b addr %h, required req 0 addr 0000180", req, rd_addr); end
        beat0 = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            valid = 1'b1;
            rd_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            sb.push_back(rd_data);
            if (i == 0) beat0 = cyc;
        end
        tick(); valid = 1'b0;
        done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy === 1'b0) begin done = 1'b1; break; end
            tick();
        end
        vectors++; if (!done) begin miscompares++; $display("FAIL basic_drain_timeout: got busy %b, required 0", busy); end
        vectors++; if (wr_cnt != 8) begin miscompares++; $display("FAIL basic_wr_count: got %0d, required 8", wr_cnt); end
        vectors++; if (first_wr_cyc != beat0 + 1) begin miscompares++; $display("FAIL basic_first_wr_cycle: got %0d, required %0d", first_wr_cyc, beat0 + 1); end
        vectors++; if (gap_seen) begin miscompares++; $display("FAIL basic_wr_consecutive: got gap, required none"); end
        vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL basic_sb_left: got %0d, required 0", sb.size()); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL basic_err: got %b, required 0", err); end
        tick(); en = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (req === 1'b1) begin done = 1'b1; break; end
            tick();
        end
        vectors++; if (!done || rd_addr !== 28'h0000180) begin miscompares++; $display("FAIL basic_next_req: got req %b addr %h, required req 1 addr 0000180", req, rd_addr); end
    endtask

    task automatic test_free_threshold();
        bit seen;
        apply_reset();
        unread = 12'hFC0; en = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (req !== 1'b0) seen = 1'b1;
            tick();
        end
        vectors++; if (seen) begin miscompares++; $display("FAIL free63_req: got req 1, required 0"); end
        unread = 12'hFBF;
        @(negedge clk);
        vectors++; if (req !== 1'b0) begin miscompares++; $display("FAIL free64_eval: got %b, required 0", req); end
        tick();
        @(negedge clk);
        vectors++; if (req !== 1'b1) begin miscompares++; $display("FAIL free64_req: got %b, required 1", req); end
    endtask

    task automatic test_conflict();
        int           drop_cyc;
        bit           done;
        logic [127:0] last_beat;
        apply_reset();
        start_addr = 28'h0000200; load = 1'b1; en = 1'b1;
        tick(); load = 1'b0;
        tick(); ack = 1'b1;
        tick(); ack = 1'b0; en = 1'b0; conflict = 1'b1;
        last_beat = 128'd0;
        for (int i = 0; i < 8; i++) begin
            tick();
            valid = 1'b1;
            rd_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            sb.push_back(rd_data);
            last_beat = rd_data;
        end
        tick(); valid = 1'b0;
        tick();
        @(negedge clk);
        vectors++; if (wr_cnt != 0) begin miscompares++; $display("FAIL conflict_no_write: got %0d writes, required 0", wr_cnt); end
        vectors++; if (l2_data !== 128'd0 || l2_rw !== 1'b0) begin miscompares++; $display("FAIL conflict_hold: got data %h rw %b, required 0 rw 0", l2_data, l2_rw); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL conflict_busy: got %b, required 1", busy); end
        tick(); conflict = 1'b0; drop_cyc = cyc;
        done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy === 1'b0) begin done = 1'b1; break; end
            tick();
        end
        vectors++; if (!done) begin miscompares++; $display("FAIL conflict_drain_timeout: got busy %b, required 0", busy); end
        vectors++; if (wr_cnt != 8) begin miscompares++; $display("FAIL conflict_wr_count: got %0d, required 8", wr_cnt); end
        vectors++; if (first_wr_cyc != drop_cyc) begin miscompares++; $display("FAIL conflict_first_wr: got %0d, required %0d", first_wr_cyc, drop_cyc); end
        vectors++; if (gap_seen) begin miscompares++; $display("FAIL conflict_consecutive: got gap, required none"); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL conflict_err: got %b, required 0", err); end
        tick(); conflict = 1'b1;
        @(negedge clk);
        vectors++; if (l2_data !== last_beat) begin miscompares++; $display("FAIL conflict_last_hold: got %h, required %h", l2_data, last_beat); end
    endtask

    task automatic test_addr_wrap();
        apply_reset();
        start_addr = 28'hFFFFF80; load = 1'b1; en = 1'b1;
        tick(); load = 1'b0;
        @(negedge clk);
        vectors++; if (req !== 1'b1 || rd_addr !== 28'hFFFFF80) begin miscompares++; $display("FAIL wrap_req: got req %b addr %h, required req 1 addr FFFFF80", req, rd_addr); end
        tick(); ack = 1'b1;
        tick(); ack = 1'b0; en = 1'b0;
        @(negedge clk);
        vectors++; if (rd_addr !== 28'h0000000) begin miscompares++; $display("FAIL wrap_addr: got %h, required 0000000", rd_addr); end
    endtask

    task automatic test_err_idle();
        apply_reset();
        repeat (10) tick();
        @(negedge clk);
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL err_before: got %b, required 0", err); end
        tick(); valid = 1'b1; rd_data = 128'hDEAD_BEEF;
        tick(); valid = 1'b0;
        @(negedge clk);
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL err_set: got %b, required 1", err); end
        repeat (5) tick();
        @(negedge clk);
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL err_sticky: got %b, required 1", err); end
        vectors++; if (wr_cnt != 0 || busy !== 1'b0) begin miscompares++; $display("FAIL err_no_write: got %0d writes busy %b, required 0 writes busy 0", wr_cnt, busy); end
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        start_addr = 28'h0000300; load = 1'b1; en = 1'b1; conflict = 1'b1;
        tick(); load = 1'b0;
        tick(); ack = 1'b1;
        tick(); ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); valid = 1'b1; rd_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        tick(); rst = 1'b1; rd_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        tick(); rst = 1'b0; conflict = 1'b0; rd_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        @(negedge clk);
        vectors++; if (req !== 1'b0 || rd_addr !== 28'h0 || rd_len !== 8'h0) begin miscompares++; $display("FAIL midrst_req: got req %b addr %h len %h, required all 0", req, rd_addr, rd_len); end
        vectors++; if (l2_en !== 1'b0 || l2_rw !== 1'b0 || l2_data !== 128'd0) begin miscompares++; $display("FAIL midrst_l2: got en %b rw %b data %h, required all 0", l2_en, l2_rw, l2_data); end
        vectors++; if (busy !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL midrst_status: got busy %b err %b, required 0 0", busy, err); end
        for (int i = 0; i < 3; i++) begin
            tick(); rd_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        tick(); valid = 1'b0;
        repeat (8) tick();
        @(negedge clk);
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL midrst_err: got %b, required 0", err); end
        vectors++; if (wr_cnt != 0) begin miscompares++; $display("FAIL midrst_writes: got %0d, required 0", wr_cnt); end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; ack = 1'b0; valid = 1'b0; conflict = 1'b0;
        start_addr = 28'h0; unread = 12'h0; rd_data = 128'd0;
        test_reset();
        test_basic_burst();
        test_free_threshold();
        test_conflict();
        test_addr_wrap();
        test_err_idle();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
